// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU-side byte bus shared by the CPU top and the memory/I/O responder.
//
// Signals:
//   mem_a          CPU address (only [17:0] are decoded by the responder)
//   mem_dout       CPU write data
//   mem_wr         1 = write, 0 = read
//   mem_din        read data back to the CPU, one cycle after the address
//   io_buffer_full TX queue near full; lets the CPU throttle its UART writes
//
// Modports:
//   master  CPU side (drives address/data/strobe)
//   slave   responder side (drives read data and the full flag)
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte bus.
//
// Holds the byte-addressed program/data RAM and the memory-mapped I/O window:
//   0x30000  read: pop UART RX byte (0 if none)    write: push byte to TX queue (0x00 ignored)
//   0x30004  read: cycle counter byte 0, snapshots the whole word
//            write: push 0x00 to TX queue and set program_stop
//   0x30005..0x30007  read: bytes 1..3 of the held snapshot
// Any address with [17:16] == 2'b11 is I/O; everything else goes to RAM.
// Reads return data one cycle after the address; writes complete at the edge.
//
// Optional feature: define MEMIO_CYCLE_CNT_EN to build the free-running cycle counter and
// snapshot. Without it, reads of 0x30004..0x30007 return 0 (writes to 0x30004 still work).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   mem_bus        CPU byte bus (slave modport)
//   tx_data        TX queue head byte
//   tx_valid       TX queue non-empty
//   tx_ready       UART accepts tx_data this cycle
//   rx_data        UART RX byte
//   rx_valid       rx_data holds a byte
//   rx_pop         one-cycle pulse consuming rx_data
//   program_stop   sticky, set by a write to 0x30004
//   txq_overflow   sticky, set on a push that was dropped because the queue was full
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_W    = 17,
    parameter int unsigned TXQ_DEPTH_LOG = 3,
    parameter int unsigned FULL_MARGIN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_io_responder_if.slave mem_bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_stop,
    output logic              txq_overflow
);

    localparam int unsigned RamBytes = 1 << RAM_ADDR_W;
    localparam int unsigned TxqDepth = 1 << TXQ_DEPTH_LOG;
    localparam int unsigned PtrW     = TXQ_DEPTH_LOG;
    localparam int unsigned CntW     = TXQ_DEPTH_LOG + 1;

    localparam logic [17:0] AddrRx   = 18'h30000;
    localparam logic [17:0] AddrCyc0 = 18'h30004;
`ifdef MEMIO_CYCLE_CNT_EN
    localparam logic [17:0] AddrCyc1 = 18'h30005;
    localparam logic [17:0] AddrCyc2 = 18'h30006;
    localparam logic [17:0] AddrCyc3 = 18'h30007;
`endif

    // ------------------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------------------
    logic [17:0]           addr;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  io_sel;
    logic                  rd_en;
    logic                  wr_en;
    logic                  unused_addr_hi;

    assign addr           = mem_bus.mem_a[17:0];
    assign ram_addr       = mem_bus.mem_a[RAM_ADDR_W-1:0];
    assign io_sel         = (addr[17:16] == 2'b11);
    assign rd_en          = !mem_bus.mem_wr;
    assign wr_en          = mem_bus.mem_wr;
    assign unused_addr_hi = ^mem_bus.mem_a[31:18];

    // ------------------------------------------------------------------------------------
    // RAM: synchronous read port, no reset on storage or read register so it maps onto
    // block RAM. The reset-clean mem_din comes from the source select below.
    // ------------------------------------------------------------------------------------
    logic [7:0] ram_q [RamBytes];
    logic [7:0] ram_rd_q;
    logic       ram_we;

    assign ram_we = wr_en && !io_sel;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_addr] <= mem_bus.mem_dout;
        end
        ram_rd_q <= ram_q[ram_addr];
    end

    // ------------------------------------------------------------------------------------
    // Cycle counter and coherent snapshot
    // ------------------------------------------------------------------------------------
    logic [7:0] cyc_rdata;

`ifdef MEMIO_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] snap_q;
    logic [31:0] snap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= 32'd0;
            snap_q <= 32'd0;
        end else begin
            cyc_q  <= cyc_q + 32'd1;
            snap_q <= snap_d;
        end
    end

    // Byte 0 comes straight from the live counter, and the same value is latched so the
    // upper bytes read on later cycles belong to the same word.
    always_comb begin
        cyc_rdata = 8'h00;
        snap_d    = snap_q;
        if (rd_en && io_sel) begin
            case (addr)
                AddrCyc0: begin
                    cyc_rdata = cyc_q[7:0];
                    snap_d    = cyc_q;
                end
                AddrCyc1: cyc_rdata = snap_q[15:8];
                AddrCyc2: cyc_rdata = snap_q[23:16];
                AddrCyc3: cyc_rdata = snap_q[31:24];
                default:  cyc_rdata = 8'h00;
            endcase
        end
    end
`else
    assign cyc_rdata = 8'h00;
`endif

    // ------------------------------------------------------------------------------------
    // TX queue state and control registers
    // ------------------------------------------------------------------------------------
    logic [7:0]      txq_q [TxqDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            io_buffer_full_q, io_buffer_full_d;
    logic            txq_overflow_q, txq_overflow_d;
    logic            program_stop_q, program_stop_d;
    logic            rx_pop_q, rx_pop_d;
    logic            sel_ram_q, sel_ram_d;
    logic [7:0]      io_rdata_q, io_rdata_d;

    logic            push_req;
    logic [7:0]      push_byte;
    logic            push;
    logic            pop;
    logic            full;

    // Bus-side decode of I/O writes into queue pushes and the stop flag.
    always_comb begin
        push_req       = 1'b0;
        push_byte      = 8'h00;
        program_stop_d = program_stop_q;
        if (wr_en && io_sel) begin
            if (addr == AddrRx) begin
                push_req  = (mem_bus.mem_dout != 8'h00);
                push_byte = mem_bus.mem_dout;
            end else if (addr == AddrCyc0) begin
                push_req       = 1'b1;
                push_byte      = 8'h00;
                program_stop_d = 1'b1;
            end
        end
    end

    // Queue bookkeeping. A push into a full queue still lands when a pop frees the slot
    // in the same cycle; otherwise it is dropped and flagged.
    always_comb begin
        full           = (cnt_q == CntW'(TxqDepth));
        pop            = (cnt_q != '0) && tx_ready;
        push           = push_req && (!full || pop);
        txq_overflow_d = txq_overflow_q || (push_req && full && !pop);

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);

        // Computed from the next count so the registered flag tracks the live count.
        io_buffer_full_d = (cnt_d >= CntW'(TxqDepth - FULL_MARGIN));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            txq_q[wr_ptr_q] <= push_byte;
        end
    end

    // Read data source for the next cycle.
    always_comb begin
        sel_ram_d  = rd_en && !io_sel;
        io_rdata_d = 8'h00;
        rx_pop_d   = 1'b0;
        if (rd_en && io_sel) begin
            if (addr == AddrRx) begin
                io_rdata_d = rx_valid ? rx_data : 8'h00;
                rx_pop_d   = rx_valid;
            end else begin
                io_rdata_d = cyc_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            io_buffer_full_q <= 1'b0;
            txq_overflow_q   <= 1'b0;
            program_stop_q   <= 1'b0;
            rx_pop_q         <= 1'b0;
            sel_ram_q        <= 1'b0;
            io_rdata_q       <= 8'h00;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            io_buffer_full_q <= io_buffer_full_d;
            txq_overflow_q   <= txq_overflow_d;
            program_stop_q   <= program_stop_d;
            rx_pop_q         <= rx_pop_d;
            sel_ram_q        <= sel_ram_d;
            io_rdata_q       <= io_rdata_d;
        end
    end

    // ------------------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------------------
    assign mem_bus.mem_din        = sel_ram_q ? ram_rd_q : io_rdata_q;
    assign mem_bus.io_buffer_full = io_buffer_full_q;
    assign tx_data                = txq_q[rd_ptr_q];
    assign tx_valid               = (cnt_q != '0);
    assign rx_pop                 = rx_pop_q;
    assign program_stop           = program_stop_q;
    assign txq_overflow           = txq_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed vectors with literal expectations, plus a
// transaction-level model (byte RAM map, TX byte queue, cycle count) compared every cycle.
module tb_mem_io_responder;

    localparam logic [31:0] Idle     = 32'h3000C;
    localparam int          Depth    = 8;
    localparam int          FullLvl  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rx_pop;
    logic       program_stop;
    logic       txq_overflow;

    int vectors     = 0;
    int miscompares = 0;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk          (clk),
        .rst          (rst),
        .mem_bus      (bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pop       (rx_pop),
        .program_stop (program_stop),
        .txq_overflow (txq_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------------------
    // Model: what the outputs must be after each edge, from the bus-level rules.
    // ---------------------------------------------------------------------------------
    logic [7:0]  ram_m [int];
    logic [7:0]  txq_m [$];
    logic [7:0]  exp_din   = 8'h00;
    bit          din_known = 1'b0;
    bit          exp_pop   = 1'b0;
    bit          exp_stop  = 1'b0;
    bit          exp_ovf   = 1'b0;
    logic [31:0] cyc_m     = 32'd0;
    logic [31:0] snap_m    = 32'd0;
    bit          model_live = 1'b0;

    always @(posedge clk) begin : model
        logic [17:0] a;
        bit          io;
        bit          pop_m;
        bit          push_req;
        logic [7:0]  push_val;
        int          size0;
        if (rst) begin
            model_live = 1'b1;
            txq_m.delete();
            exp_din   = 8'h00;
            din_known = 1'b1;
            exp_pop   = 1'b0;
            exp_stop  = 1'b0;
            exp_ovf   = 1'b0;
            cyc_m     = 32'd0;
            snap_m    = 32'd0;
        end else begin
            a        = bus.mem_a[17:0];
            io       = (a[17:16] == 2'b11);
            size0    = txq_m.size();
            pop_m    = (size0 != 0) && tx_ready;
            push_req = 1'b0;
            push_val = 8'h00;
            exp_pop  = 1'b0;
            if (bus.mem_wr) begin
                exp_din   = 8'h00;
                din_known = 1'b1;
                if (!io) begin
                    ram_m[int'(a[16:0])] = bus.mem_dout;
                end else if (a == 18'h30000 && bus.mem_dout != 8'h00) begin
                    push_req = 1'b1;
                    push_val = bus.mem_dout;
                end else if (a == 18'h30004) begin
                    push_req = 1'b1;
                    exp_stop = 1'b1;
                end
            end else if (!io) begin
                din_known = ram_m.exists(int'(a[16:0]));
                if (din_known) exp_din = ram_m[int'(a[16:0])];
            end else begin
                din_known = 1'b1;
                exp_din   = 8'h00;
                if (a == 18'h30000) begin
                    exp_din = rx_valid ? rx_data : 8'h00;
                    exp_pop = rx_valid;
                end
`ifdef MEMIO_CYCLE_CNT_EN
                else if (a == 18'h30004) begin
                    snap_m  = cyc_m;
                    exp_din = cyc_m[7:0];
                end
                else if (a == 18'h30005) exp_din = snap_m[15:8];
                else if (a == 18'h30006) exp_din = snap_m[23:16];
                else if (a == 18'h30007) exp_din = snap_m[31:24];
`endif
            end
            if (pop_m) void'(txq_m.pop_front());
            if (push_req) begin
                if (size0 == Depth && !pop_m) exp_ovf = 1'b1;
                else txq_m.push_back(push_val);
            end
            cyc_m = cyc_m + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            if (din_known) check("mem_din", {24'd0, bus.mem_din}, {24'd0, exp_din});
            check("rx_pop", {31'd0, rx_pop}, {31'd0, exp_pop});
            check("program_stop", {31'd0, program_stop}, {31'd0, exp_stop});
            check("txq_overflow", {31'd0, txq_overflow}, {31'd0, exp_ovf});
            check("io_buffer_full", {31'd0, bus.io_buffer_full},
                  {31'd0, txq_m.size() >= FullLvl});
            check("tx_valid", {31'd0, tx_valid}, {31'd0, txq_m.size() != 0});
            if (txq_m.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, txq_m[0]});
        end
    end

    // ---------------------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------------------
    task automatic bus_op(input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_wr   = w;
        bus.mem_dout = d;
        @(posedge clk);
        #1;
        bus.mem_a    = Idle;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0]  drain_exp [8];
    logic [31:0] word;

    initial begin
        bus.mem_a    = Idle;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'h00;
        repeat (3) tick();
        check("reset mem_din", {24'd0, bus.mem_din}, 32'h0);
        check("reset tx_valid", {31'd0, tx_valid}, 32'h0);
        check("reset program_stop", {31'd0, program_stop}, 32'h0);
        check("reset txq_overflow", {31'd0, txq_overflow}, 32'h0);
        check("reset io_buffer_full", {31'd0, bus.io_buffer_full}, 32'h0);
        rst = 1'b0;

        // RAM write then read
        bus_op(32'h00010, 1'b1, 8'hA5);
        check("mem_din after write", {24'd0, bus.mem_din}, 32'h0);
        bus_op(32'h00010, 1'b0, 8'h00);
        check("ram read 0x10", {24'd0, bus.mem_din}, 32'hA5);

        // Back-to-back reads
        bus_op(32'h0, 1'b1, 8'h11);
        bus_op(32'h1, 1'b1, 8'h22);
        bus_op(32'h2, 1'b1, 8'h33);
        bus_op(32'h0, 1'b0, 8'h00);
        check("b2b read 0", {24'd0, bus.mem_din}, 32'h11);
        bus_op(32'h1, 1'b0, 8'h00);
        check("b2b read 1", {24'd0, bus.mem_din}, 32'h22);
        bus_op(32'h2, 1'b0, 8'h00);
        check("b2b read 2", {24'd0, bus.mem_din}, 32'h33);

        // Fill TX queue with the UART stalled
        tx_ready = 1'b0;
        bus_op(32'h30000, 1'b1, 8'h48);
        bus_op(32'h30000, 1'b1, 8'h69);
        bus_op(32'h30000, 1'b1, 8'h00);
        check("zero byte not queued", {31'd0, bus.io_buffer_full}, 32'h0);
        for (int i = 1; i <= 3; i++) bus_op(32'h30000, 1'b1, 8'(i));
        check("not full at 5", {31'd0, bus.io_buffer_full}, 32'h0);
        bus_op(32'h30000, 1'b1, 8'h04);
        check("full at 6", {31'd0, bus.io_buffer_full}, 32'h1);
        bus_op(32'h30000, 1'b1, 8'h05);
        bus_op(32'h30000, 1'b1, 8'h06);
        check("no overflow at 8", {31'd0, txq_overflow}, 32'h0);
        bus_op(32'h30000, 1'b1, 8'h07);
        check("overflow on 9th", {31'd0, txq_overflow}, 32'h1);

        drain_exp = '{8'h48, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain order", {24'd0, tx_data}, {24'd0, drain_exp[k]});
            tick();
        end
        check("drained empty", {31'd0, tx_valid}, 32'h0);

        // Steady state at full depth: push and pop every cycle
        do_reset();
        check("overflow cleared", {31'd0, txq_overflow}, 32'h0);
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_op(32'h30000, 1'b1, 8'h10 + 8'(i));
        check("full depth", {31'd0, bus.io_buffer_full}, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) bus_op(32'h30000, 1'b1, 8'h20 + 8'(i));
        check("steady no overflow", {31'd0, txq_overflow}, 32'h0);
        check("steady still full", {31'd0, bus.io_buffer_full}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            check("steady drain", {24'd0, tx_data}, {24'd0, 8'h22 + 8'(k)});
            tick();
        end
        check("steady drained", {31'd0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Cycle counter snapshot
        repeat (1000) tick();
        bus_op(32'h30004, 1'b0, 8'h00);
        word[7:0] = bus.mem_din;
        bus_op(32'h30005, 1'b0, 8'h00);
        word[15:8] = bus.mem_din;
        bus_op(32'h30006, 1'b0, 8'h00);
        word[23:16] = bus.mem_din;
        bus_op(32'h30007, 1'b0, 8'h00);
        word[31:24] = bus.mem_din;
`ifdef MEMIO_CYCLE_CNT_EN
        check("cycle snapshot word", word, snap_m);
        check("cycle snapshot > 1000", {31'd0, word > 32'd1000}, 32'h1);
`else
        check("cycle snapshot disabled", word, 32'h0);
`endif

        // UART RX
        rx_valid = 1'b1;
        rx_data  = 8'h7A;
        bus_op(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx data", {24'd0, bus.mem_din}, 32'h7A);
        check("rx_pop pulse", {31'd0, rx_pop}, 32'h1);
        tick();
        check("rx_pop single", {31'd0, rx_pop}, 32'h0);
        bus_op(32'h30000, 1'b0, 8'h00);
        check("rx empty data", {24'd0, bus.mem_din}, 32'h0);
        check("rx empty no pop", {31'd0, rx_pop}, 32'h0);

        // Program stop and reset mid-operation
        bus_op(32'h30004, 1'b1, 8'h55);
        check("program_stop set", {31'd0, program_stop}, 32'h1);
        check("stop byte queued", {31'd0, tx_valid}, 32'h1);
        check("stop byte value", {24'd0, tx_data}, 32'h0);
        bus.mem_a = 32'h00010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_a = Idle;
        check("rst clears stop", {31'd0, program_stop}, 32'h0);
        check("rst flushes queue", {31'd0, tx_valid}, 32'h0);
        check("rst clears mem_din", {24'd0, bus.mem_din}, 32'h0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
